// File: rtl/aes_cbc_encryptor_if.sv
// Block-level handshake bundle for the CBC encryptor: plaintext/key in, ciphertext out.
interface aes_cbc_encryptor_if;
  logic [127:0] datain;
  logic         dat_stb;
  logic [127:0] key;
  logic         key_valid;
  logic         o_stb;
  logic [127:0] dataout;
  logic         o_valid;
  logic         ready;

  modport slave (
    input  datain, dat_stb, key, key_valid, o_stb,
    output dataout, o_valid, ready
  );

  modport master (
    output datain, dat_stb, key, key_valid, o_stb,
    input  dataout, o_valid, ready
  );
endinterface

// File: rtl/aes_cbc_encryptor.sv
// Iterative AES-128 CBC encryptor: one round per clock, round keys expanded on the fly.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y_o = SBOX[a_i];
endmodule

// state | meaning
// IDLE  | ready = 1, waiting for plaintext with a valid key
// BUSY  | rounds 1..10 in progress
// DONE  | o_valid = 1, ciphertext held until the consumer takes it
module aes_cbc_encryptor #(
  parameter logic [127:0] INITIAL_VEC = 128'h000102030405060708090A0B0C0D0E0F
) (
  input  logic                       clk,
  input  logic                       reset,
  aes_cbc_encryptor_if.slave         bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

  fsm_e         fsm_q;
  logic [127:0] state_q, rkey_q, chain_q, dataout_q;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;
  logic         o_valid_q, ready_q;

  logic [7:0]   sb [16];
  logic [127:0] sr_w, mc_w, nkey_d, state_d;
  logic [31:0]  ksub, ktemp;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // Byte i of the state sits at bits [127-8i -: 8], column-major as in FIPS-197.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (.a_i(state_q[127-8*i -: 8]), .y_o(sb[i]));
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_w[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
    end
    assign mc_w[127-32*c -: 32] = mix_col(sr_w[127-32*c -: 32]);
  end

  // SubWord before RotWord is equivalent and lets the S-boxes sit directly on w3.
  for (genvar i = 0; i < 4; i++) begin : g_ks
    aes_sbox u_sbox (.a_i(rkey_q[31-8*i -: 8]), .y_o(ksub[31-8*i -: 8]));
  end

  assign ktemp = {ksub[23:0], ksub[31:24]} ^ {rcon_q, 24'h0};

  always_comb begin
    nkey_d[127:96] = rkey_q[127:96] ^ ktemp;
    nkey_d[95:64]  = rkey_q[95:64]  ^ nkey_d[127:96];
    nkey_d[63:32]  = rkey_q[63:32]  ^ nkey_d[95:64];
    nkey_d[31:0]   = rkey_q[31:0]   ^ nkey_d[63:32];
    state_d        = ((round_q == 4'd10) ? sr_w : mc_w) ^ nkey_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      rkey_q    <= '0;
      chain_q   <= INITIAL_VEC;
      dataout_q <= '0;
      rcon_q    <= '0;
      round_q   <= '0;
      o_valid_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (ready_q && bus.dat_stb && bus.key_valid) begin
            state_q <= bus.datain ^ chain_q ^ bus.key;
            rkey_q  <= bus.key;
            rcon_q  <= 8'h01;
            round_q <= 4'd1;
            ready_q <= 1'b0;
            fsm_q   <= BUSY;
          end
        end
        BUSY: begin
          state_q <= state_d;
          rkey_q  <= nkey_d;
          rcon_q  <= xt(rcon_q);
          if (round_q == 4'd10) begin
            dataout_q <= state_d;
            o_valid_q <= 1'b1;
            round_q   <= 4'd0;
            fsm_q     <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          // The chain only advances on a consumed ciphertext.
          if (o_valid_q && bus.o_stb) begin
            chain_q   <= dataout_q;
            o_valid_q <= 1'b0;
            ready_q   <= 1'b1;
            fsm_q     <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.dataout = dataout_q;
  assign bus.o_valid = o_valid_q;
  assign bus.ready   = ready_q;
endmodule

// File: tb/tb_aes_cbc_encryptor.sv
// Directed-vector bench for aes_cbc_encryptor: FIPS-197 C.1 and SP800-38A CBC vectors.
module tb_aes_cbc_encryptor;
  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] X_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_SP  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1    = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2    = 128'h5086cb9b507219ee95db113a917678b2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] p_r = '0, k_r = '0;
  logic ds_r = 1'b0, kv_r = 1'b0, os_r = 1'b0;
  logic sel = 1'b0;
  bit   scramble = 1'b0;
  int   n_cmp = 0, n_bad = 0;

  aes_cbc_encryptor_if if0();
  aes_cbc_encryptor_if if1();

  assign if0.datain    = p_r;
  assign if0.key       = k_r;
  assign if0.key_valid = kv_r;
  assign if0.dat_stb   = ds_r & ~sel;
  assign if0.o_stb     = os_r & ~sel;
  assign if1.datain    = p_r;
  assign if1.key       = k_r;
  assign if1.key_valid = kv_r;
  assign if1.dat_stb   = ds_r & sel;
  assign if1.o_stb     = os_r & sel;

  aes_cbc_encryptor #(.INITIAL_VEC(128'h0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  aes_cbc_encryptor dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  wire [127:0] dout = sel ? if1.dataout : if0.dataout;
  wire         vld  = sel ? if1.o_valid : if0.o_valid;
  wire         rdy  = sel ? if1.ready   : if0.ready;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [127:0] p);
    p_r  = p;
    kv_r = 1'b1;
    ds_r = 1'b1;
    tick();
    ds_r = 1'b0;
    check("accept_ready_low", rdy, 0);
  endtask

  task automatic wait_done(output logic [127:0] c, output int lat, output bit rdy_seen);
    lat = 0;
    rdy_seen = 1'b0;
    while (lat < 30) begin
      if (scramble) k_r = {$urandom, $urandom, $urandom, $urandom};
      tick();
      lat++;
      if (rdy) rdy_seen = 1'b1;
      if (vld) break;
    end
    c = dout;
  endtask

  task automatic take();
    os_r = 1'b1;
    tick();
    os_r = 1'b0;
    check("take_valid_low", vld, 0);
    check("take_ready_high", rdy, 1);
  endtask

  task automatic do_reset();
    ds_r  = 1'b0;
    os_r  = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_ready", rdy, 1);
    check("reset_valid", vld, 0);
  endtask

  initial begin
    logic [127:0] c, held;
    int  lat;
    bit  rs;

    tick();
    tick();
    reset = 1'b0;
    check("rst0_ready", if0.ready, 1);
    check("rst0_valid", if0.o_valid, 0);
    check("rst0_dout", if0.dataout, 0);
    check("rst1_ready", if1.ready, 1);
    check("rst1_valid", if1.o_valid, 0);
    check("rst1_dout", if1.dataout, 0);

    // FIPS-197 C.1 on the zero-IV instance
    sel = 1'b0;
    k_r = K_C1;
    start_block(P_C1);
    wait_done(c, lat, rs);
    check("c1_latency", 128'(lat), 10);
    check("c1_ready_busy", 128'(rs), 0);
    check("c1_cipher", c, X_C1);
    take();

    // Handshake gating on the default-IV instance
    sel = 1'b1;
    k_r = K_SP;
    p_r = P1;
    kv_r = 1'b0;
    ds_r = 1'b1;
    repeat (3) tick();
    ds_r = 1'b0;
    check("nokey_ready", rdy, 1);
    check("nokey_valid", vld, 0);
    kv_r = 1'b1;
    repeat (3) begin
      os_r = 1'b1;
      tick();
      os_r = 1'b0;
      tick();
    end
    check("idle_ostb_ready", rdy, 1);
    check("idle_ostb_valid", vld, 0);

    start_block(P1);
    wait_done(c, lat, rs);
    check("sp1_latency", 128'(lat), 10);
    check("sp1_cipher", c, C1);

    // Backpressure: ciphertext held, stray dat_stb ignored
    held = dout;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        p_r  = P2;
        ds_r = 1'b1;
      end
      tick();
      ds_r = 1'b0;
      check("bp_valid", vld, 1);
      check("bp_dout", dout, held);
      check("bp_ready", rdy, 0);
    end
    take();
    tick();
    check("post_take_valid", vld, 0);
    check("post_take_ready", rdy, 1);

    start_block(P2);
    wait_done(c, lat, rs);
    check("sp2_cipher", c, C2);
    take();

    // Reset mid-round of P2 after C1 was taken
    do_reset();
    start_block(P1);
    wait_done(c, lat, rs);
    check("sp1b_cipher", c, C1);
    take();
    start_block(P2);
    repeat (4) tick();
    do_reset();
    repeat (12) tick();
    check("abort_no_valid", vld, 0);
    check("abort_ready", rdy, 1);
    start_block(P1);
    wait_done(c, lat, rs);
    check("iv_restored_cipher", c, C1);
    take();

    // Key changes while busy must not disturb the block in flight
    do_reset();
    scramble = 1'b1;
    start_block(P1);
    wait_done(c, lat, rs);
    scramble = 1'b0;
    k_r = K_SP;
    check("keychg_latency", 128'(lat), 10);
    check("keychg_cipher", c, C1);
    take();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_cbc_encryptor.md
Name: aes_cbc_encryptor

Overview:
- Iterative AES-128 encryptor in CBC mode. Runs one round per clock and expands the round keys on the fly.
- It is the transmit-side counterpart of the team's CBC decryptor and uses the same handshake: `ready`, `dat_stb`/`key_valid` in, `o_valid`/`o_stb` out.
- Each accepted plaintext block is XORed with the previous ciphertext (the IV for the first block), encrypted, and held until the consumer takes it.

Parameters:
- `INITIAL_VEC`, default `128'h000102030405060708090A0B0C0D0E0F`: CBC IV loaded into the chain register on reset.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `datain` in 128: plaintext block. Bit 127 is FIPS-197 byte 0.
- `dat_stb` in 1: plaintext valid.
- `key` in 128: cipher key, FIPS-197 byte order.
- `key_valid` in 1: key valid.
- `o_stb` in 1: consumer accepts `dataout`.
- `dataout` out 128: ciphertext block.
- `o_valid` out 1: `dataout` holds an untaken ciphertext.
- `ready` out 1: block can accept a new plaintext.

Behaviour:
- Reset values:
  - `ready` = 1, `o_valid` = 0, `dataout` = 0.
  - Chain register = `INITIAL_VEC`; round counter = 0; state, round key and rcon are cleared.
- Accept condition `acc` = `ready && dat_stb && key_valid`, sampled at edge T. On `acc`:
  - state ← `datain ^ chain ^ key`
  - round key register ← `key`
  - rcon ← `8'h01`
  - round counter ← 1
  - `ready` ← 0
- Inputs are ignored while `ready` = 0; `dat_stb` with `key_valid` = 0 is not accepted.
- Rounds: at edges T+1 … T+10, with r = round counter:
  - Next round key = expand(round key, rcon), following the FIPS-197 schedule: RotWord, SubWord, XOR rcon into the MSB byte, then chained word XORs.
  - Rounds r = 1…9: state ← MixColumns(ShiftRows(SubBytes(state))) ^ next round key.
  - Round r = 10: MixColumns is omitted.
  - rcon advances by xtime: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Implementation constraints: forward S-box only, as 16 state instances plus 4 key-schedule instances. No precomputed key table.
- States:
  - IDLE: `ready` = 1.
  - BUSY: counter 1..10.
  - DONE: `o_valid` = 1.
- Transitions:
  - IDLE → BUSY on `acc`.
  - BUSY → DONE at edge T+10.
  - DONE → IDLE on `o_valid && o_stb`.
- Completion (edge T+10):
  - `dataout` ← final state; `o_valid` ← 1.
  - Latency from the accept edge to `o_valid` high is exactly 10 cycles.
- `dataout` is stable while `o_valid` = 1.
- Output handshake, at the edge where `o_valid && o_stb`:
  - chain ← `dataout`; `o_valid` ← 0; `ready` ← 1.
  - A new block may be accepted from the next edge onward. Minimum issue interval is 12 cycles, with `o_stb` held high.
- `o_stb` while `o_valid` = 0 has no effect, and the chain is not updated.
- A held ciphertext never updates the chain until it is taken. Back-to-back blocks therefore chain only on consumed outputs.
- `ready` and `o_valid` are never both 1.
- Reset at any point aborts the operation in progress: all registers return to reset values, the partial result is discarded and the chain reverts to `INITIAL_VEC`.
- The key is sampled only at `acc`. Changing `key` during BUSY does not affect the block in flight.

Test Plan:
- FIPS-197 C.1, override `INITIAL_VEC` = 0:
  - Stimulus: key `000102030405060708090a0b0c0d0e0f`, `datain` `00112233445566778899aabbccddeeff`.
  - Response: `o_valid` rises exactly 10 cycles after `acc`; `dataout` = `69c4e0d86a7b0430d8cdb78070b4c55a`; `ready` = 0 throughout.
- SP800-38A F.2.1, default IV, key `2b7e151628aed2a6abf7158809cf4f3c`:
  - P1 `6bc1bee22e409f96e93d7e117393172a` → C1 `7649abac8119b246cee98e9b12e9197d`.
  - Take C1 with `o_stb`, then P2 `ae2d8a571e03ac9c9eb76fac45af8e51` → C2 `5086cb9b507219ee95db113a917678b2`.
- Output backpressure:
  - Hold `o_stb` = 0 for 20 cycles after C1: `o_valid` stays 1, `dataout` is unchanged, `ready` stays 0.
  - A `dat_stb` pulse in that window is ignored.
  - After `o_stb`: `ready` = 1 on the next cycle.
- Handshake gating:
  - `dat_stb` = 1 with `key_valid` = 0: no accept.
  - `o_stb` pulses while idle: chain is unchanged, so a subsequent P1 still gives C1 = `7649abac…`.
- Reset mid-round:
  - Assert `reset` at round 5 of P2 (after C1 was taken): `o_valid` = 0, `ready` = 1 next cycle.
  - Re-encrypting P1 gives `7649abac8119b246cee98e9b12e9197d`, proving the IV was restored.
- Key change in flight: drive `key` to random values during BUSY; the ciphertext still equals C1.
